sha256_message_schedule: RTL and testbench

Producer side of the round datapath's `word` input. It accepts one 512-bit message block and streams the 64 SHA-256 schedule words W0..W63, one per handshake, into the round logic. That round logic forms T1 from e/f/g/h/const/word and T2 from a/b/c. The block uses a 16-word sliding window, so only one new word is computed per transfer. It sits between block buffering and the round-constant/compression sequencer.

---
 rtl/sha256_message_schedule.sv | 95 +++++++++
 tb/tb_sha256_message_schedule.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sha256_message_schedule.sv
// sha256_message_schedule
// Streams the SHA-256 message schedule W0..W(NUM_WORDS-1) for one 512-bit
// block, one word per valid/ready transfer, into the compression round logic.
// A 16-word sliding window holds W(t)..W(t+15). Each transfer shifts the
// window by one word and registers the freshly computed W(t+16) into the tail.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - load block_in; only honoured in IDLE
//   block_in   - 512-bit message block, big-endian (W0 = block_in[511:480])
//   word_ready - consumer accepts word_out this cycle
//   word_out   - current schedule word Wt (direct register output)
//   word_index - t of word_out
//   word_valid - word_out/word_index valid
//   busy       - high while a block is being streamed
//   done       - one-cycle pulse after the last word is transferred
module sha256_message_schedule #(
  parameter int NUM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         word_ready,
  output logic [31:0]  word_out,
  output logic [5:0]   word_index,
  output logic         word_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_idx;
  logic [31:0] r_win [16];   // r_win[0] = W(t), r_win[15] = W(t+15)

  logic        w_xfer;
  logic        w_last;
  logic        w_tail_en;
  logic [31:0] w_tail;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_xfer    = (r_state == S_RUN) && word_ready;
  assign w_last    = (r_idx == 6'(NUM_WORDS - 1));
  // Words beyond the end of the schedule are never presented, so skip them.
  assign w_tail_en = ({1'b0, r_idx} + 7'd16) < 7'(NUM_WORDS);
  // W(t+16) from the current window; modulo-2^32 by truncation.
  assign w_tail    = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 6'd0;
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) r_win[i] <= block_in[511 - 32*i -: 32];
            r_idx   <= 6'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            if (w_tail_en) r_win[15] <= w_tail;
            r_idx <= r_idx + 6'd1;
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;   // start here is dropped, not queued
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_out   = r_win[0];
  assign word_index = r_idx;
  assign word_valid = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_sha256_message_schedule.sv
`timescale 1ns/1ps
module tb_sha256_message_schedule;

  localparam int NW = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         word_ready = 1'b0;
  logic [31:0]  word_out;
  logic [5:0]   word_index;
  logic         word_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_w [NW];
  logic [31:0] got_w [NW];

  sha256_message_schedule #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
    .word_ready(word_ready), .word_out(word_out), .word_index(word_index),
    .word_valid(word_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic gen_sched(input logic [511:0] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < NW; i++)
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
  endtask

  task automatic scramble();
    for (int k = 0; k < 16; k++) block_in[32*k +: 32] = $urandom;
  endtask

  // Stream one block. rnd: random word_ready; poke: start at t=20 and in DONE;
  // scram: block_in changes every cycle after accept; abort_at: reset at that t.
  task automatic run_blk(input logic [511:0] blk, input bit rnd, input bit poke,
                         input bit scram, input int abort_at);
    int t, cyc, nvalid;
    bit rdy;
    gen_sched(blk);
    @(negedge clk);
    block_in = blk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scram) scramble();
    chk("first_valid", 32'(word_valid), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);
    t = 0; cyc = 0; nvalid = 0;
    while (t < NW && cyc < 2000) begin
      if (t == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word", word_out, 32'd0);
        chk("rst_index", 32'(word_index), 32'd0);
        start = 1'b0; word_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      chk("valid", 32'(word_valid), 32'd1);
      chk("index", 32'(word_index), 32'(t));
      chk($sformatf("W%0d", t), word_out, exp_w[t]);
      nvalid++;
      start = poke && (t == 20);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      word_ready = rdy;
      if (rdy) got_w[t] = word_out;
      if (scram) scramble();
      @(negedge clk);
      cyc++;
      if (rdy) t++;
    end
    chk("no_timeout", 32'(cyc < 2000), 32'd1);
    if (!rnd) chk("valid_cycles", 32'(nvalid), 32'(NW));
    word_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(word_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_valid", 32'(word_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  logic [511:0] abc, ones, ramp;

  initial begin
    abc  = {32'h61626380, 448'd0, 32'h00000018};
    ones = {16{32'hFFFFFFFF}};
    for (int i = 0; i < 16; i++) ramp[511 - 32*i -: 32] = 32'h9E3779B9 * (i + 1);

    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(word_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_word", word_out, 32'd0);
    chk("reset_index", 32'(word_index), 32'd0);
    rst_n = 1'b1;

    // 1: FIPS "abc" block, ready held high
    run_blk(abc, 1'b0, 1'b0, 1'b0, -1);
    chk("abc_W0", got_w[0], 32'h61626380);
    chk("abc_W15", got_w[15], 32'h00000018);
    chk("abc_W16", got_w[16], 32'h61626380);
    chk("abc_W17", got_w[17], 32'h000F0000);

    // 2: same block, random backpressure
    run_blk(abc, 1'b1, 1'b0, 1'b0, -1);
    chk("stall_W17", got_w[17], 32'h000F0000);

    // 3: stray starts at t=20 and in DONE are ignored
    run_blk(abc, 1'b0, 1'b1, 1'b0, -1);

    // 4: asynchronous reset mid-block
    run_blk(ramp, 1'b1, 1'b0, 1'b0, 40);

    // 5: all-ones block exercises modulo wrap
    run_blk(ones, 1'b0, 1'b0, 1'b0, -1);
    chk("ones_W0", got_w[0], 32'hFFFFFFFF);
    chk("ones_W16", got_w[16], 32'h203FFFFC);

    // 6: block_in churns after accept
    run_blk(ramp, 1'b1, 1'b0, 1'b1, -1);
    chk("scram_W0", got_w[0], 32'h9E3779B9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
